stacker_engine: RTL and testbench

- Parametrised successor of the single-block stacker game FSM.
- A block of configurable width sweeps back and forth across the current row. On each drop, the part of the block that overhangs the row below is trimmed away. The game is won when the top row is filled and lost when a block misses the stack completely.
- Sits between the button/timer front end and the LED matrix row driver. Outputs a flattened ROWS x COLS frame plus game status.

---
 rtl/stacker_pkg.sv | 42 ++++
 rtl/stacker_row_eval.sv | 30 +++
 rtl/stacker_engine.sv | 207 ++++++++++++++++++++
 tb/tb_stacker_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// rtl/stacker_pkg.sv - state type, width helpers and block mask builder for stacker_engine
package stacker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        MOVE,
        CHECK,
        UPDATE,
        FAIL,
        WIN
    } state_e;

    // Upper bound on COLS supported by block_mask
    localparam int unsigned MAX_COLS = 64;

    function automatic int unsigned row_idx_w(input int unsigned rows);
        return $clog2(rows);
    endfunction

    function automatic int unsigned width_w(input int unsigned cols);
        return $clog2(cols + 1);
    endfunction

    function automatic int unsigned score_w(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

    function automatic int unsigned pos_w(input int unsigned cols);
        return $clog2(cols);
    endfunction

    function automatic logic [MAX_COLS-1:0] block_mask(input int unsigned pos, input int unsigned w);
        logic [MAX_COLS-1:0] m;
        m = '0;
        for (int unsigned c = 0; c < MAX_COLS; c++) begin
            if (c >= pos && c < pos + w) m[c] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/stacker_row_eval.sv
// rtl/stacker_row_eval.sv - overlap of the dropped row with the row beneath it
module stacker_row_eval
    import stacker_pkg::*;
#(
    parameter int unsigned COLS = 8
) (
    input  logic [COLS-1:0]              cur_row_i,
    input  logic [COLS-1:0]              below_row_i,
    output logic [COLS-1:0]              overlap_o,
    output logic [width_w(COLS)-1:0]     popcount_o,
    output logic [pos_w(COLS)-1:0]       low_idx_o,
    output logic                         zero_o
);

    localparam int unsigned WID_W = width_w(COLS);
    localparam int unsigned POS_W = pos_w(COLS);

    assign overlap_o = cur_row_i & below_row_i;
    assign zero_o    = (overlap_o == '0);

    always_comb begin
        popcount_o = '0;
        low_idx_o  = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            popcount_o = popcount_o + WID_W'(overlap_o[c]);
            if (overlap_o[c]) low_idx_o = POS_W'(c);
        end
    end

endmodule

// File: rtl/stacker_engine.sv
// rtl/stacker_engine.sv - stacker game FSM and block movement; STACKER_SPEEDUP_EN adds a per-row tick divider
module stacker_engine
    import stacker_pkg::*;
#(
    parameter int unsigned COLS     = 8,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned BLOCK_W  = 3,
    parameter int unsigned BASE_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rstBtn,
    input  logic                        start,
    input  logic                        dropBtn,
    input  logic                        tick,
    output logic [ROWS*COLS-1:0]        lineDisplay,
    output logic [row_idx_w(ROWS)-1:0]  curRow,
    output logic [width_w(COLS)-1:0]    blkWidth,
    output logic [score_w(ROWS)-1:0]    score,
    output logic                        EOG,
    output logic                        win
);

    localparam int unsigned ROW_W = row_idx_w(ROWS);
    localparam int unsigned WID_W = width_w(COLS);
    localparam int unsigned SCO_W = score_w(ROWS);
    localparam int unsigned POS_W = pos_w(COLS);

    state_e                 state_q, state_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   dir_q, dir_d;
    logic [WID_W-1:0]       w_q, w_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [SCO_W-1:0]       score_q, score_d;
    logic [ROWS*COLS-1:0]   frame_q, frame_d;
    logic                   eog_q, eog_d;
    logic                   win_q, win_d;

    logic [ROW_W-1:0]       row_below;
    logic [COLS-1:0]        cur_row, below_row, overlap;
    logic [WID_W-1:0]       ovl_count;
    logic [POS_W-1:0]       ovl_low;
    logic                   ovl_zero;
    logic [MAX_COLS-1:0]    mask_full;
    logic                   move_strobe;

    assign row_below = row_q - 1'b1;
    assign cur_row   = frame_q[row_q*COLS +: COLS];
    assign below_row = frame_q[row_below*COLS +: COLS];

    stacker_row_eval #(.COLS(COLS)) u_row_eval (
        .cur_row_i   (cur_row),
        .below_row_i (below_row),
        .overlap_o   (overlap),
        .popcount_o  (ovl_count),
        .low_idx_o   (ovl_low),
        .zero_o      (ovl_zero)
    );

`ifdef STACKER_SPEEDUP_EN
    localparam int unsigned DIV_W = $clog2(BASE_DIV + 1);
    logic [DIV_W-1:0] div_q, div_d;

    // Higher rows move faster: one strobe every max(1, BASE_DIV-row) ticks
    always_comb begin
        int n;
        div_d       = div_q;
        move_strobe = 1'b0;
        n           = int'(BASE_DIV) - int'(row_q);
        if (n < 1) n = 1;
        if (state_q == SPAWN) begin
            div_d = '0;
        end else if (state_q == MOVE && tick && !dropBtn) begin
            if (int'(div_q) >= n - 1) begin
                div_d       = '0;
                move_strobe = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstBtn) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    assign move_strobe = tick;
`endif

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        w_d       = w_q;
        row_d     = row_q;
        score_d   = score_q;
        frame_d   = frame_q;
        eog_d     = eog_q;
        win_d     = win_q;
        mask_full = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SPAWN;
            end
            SPAWN: begin
                pos_d     = '0;
                dir_d     = 1'b0;
                mask_full = block_mask(0, 32'(w_q));
                frame_d[row_q*COLS +: COLS] = mask_full[COLS-1:0];
                state_d   = MOVE;
            end
            MOVE: begin
                if (dropBtn) begin
                    state_d = CHECK;
                end else if (move_strobe && 32'(w_q) != COLS) begin
                    // Bounce happens within the same strobe as the edge hit
                    if (!dir_q) begin
                        if (32'(pos_q) + 32'(w_q) == COLS) begin
                            dir_d = 1'b1;
                            pos_d = pos_q - 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = 1'b0;
                            pos_d = pos_q + 1'b1;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                    mask_full = block_mask(32'(pos_d), 32'(w_q));
                    frame_d[row_q*COLS +: COLS] = mask_full[COLS-1:0];
                end
            end
            CHECK: begin
                if (row_q == '0) begin
                    state_d = UPDATE;
                end else if (ovl_zero) begin
                    eog_d   = 1'b1;
                    win_d   = 1'b0;
                    state_d = FAIL;
                end else begin
                    frame_d[row_q*COLS +: COLS] = overlap;
                    w_d     = ovl_count;
                    pos_d   = ovl_low;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                score_d = score_q + 1'b1;
                if (32'(row_q) == ROWS - 1) begin
                    eog_d   = 1'b1;
                    win_d   = 1'b1;
                    state_d = WIN;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = SPAWN;
                end
            end
            FAIL, WIN: begin
                if (start) begin
                    frame_d = '0;
                    score_d = '0;
                    w_d     = WID_W'(BLOCK_W);
                    row_d   = '0;
                    eog_d   = 1'b0;
                    win_d   = 1'b0;
                    state_d = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstBtn) begin
            state_q <= IDLE;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            w_q     <= WID_W'(BLOCK_W);
            row_q   <= '0;
            score_q <= '0;
            frame_q <= '0;
            eog_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            w_q     <= w_d;
            row_q   <= row_d;
            score_q <= score_d;
            frame_q <= frame_d;
            eog_q   <= eog_d;
            win_q   <= win_d;
        end
    end

    assign lineDisplay = frame_q;
    assign curRow      = row_q;
    assign blkWidth    = w_q;
    assign score       = score_q;
    assign EOG         = eog_q;
    assign win         = win_q;

endmodule

// File: tb/tb_stacker_engine.sv
// tb/tb_stacker_engine.sv - directed scoreboard bench for stacker_engine (8x8, BLOCK_W=3)
module tb_stacker_engine;

    localparam int COLS = 8;
    localparam int ROWS = 8;

    logic        clk = 1'b0;
    logic        rstBtn, start, dropBtn, tick;
    logic [63:0] lineDisplay;
    logic [2:0]  curRow;
    logic [3:0]  blkWidth;
    logic [3:0]  score;
    logic        EOG, win;

    always #5 clk = ~clk;

    stacker_engine #(.COLS(COLS), .ROWS(ROWS), .BLOCK_W(3), .BASE_DIV(4)) dut (
        .clk         (clk),
        .rstBtn      (rstBtn),
        .start       (start),
        .dropBtn     (dropBtn),
        .tick        (tick),
        .lineDisplay (lineDisplay),
        .curRow      (curRow),
        .blkWidth    (blkWidth),
        .score       (score),
        .EOG         (EOG),
        .win         (win)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_val(input string tag, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [63:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [7:0] bm(input int pos, input int w);
        logic [7:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) if (c >= pos && c < pos + w) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] rowv(input int r);
        return lineDisplay[r*COLS +: COLS];
    endfunction

    function automatic int tpm(input int r);
`ifdef STACKER_SPEEDUP_EN
        return (4 - r < 1) ? 1 : 4 - r;
`else
        return (r < 0) ? 0 : 1;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int r);
        repeat (tpm(r)) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic drop();
        dropBtn = 1'b1;
        cyc();
        dropBtn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic new_game();
        rstBtn = 1'b1;
        cyc();
        rstBtn = 1'b0;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        cyc();
    endtask

    initial begin
        rstBtn = 1'b1; start = 1'b0; dropBtn = 1'b0; tick = 1'b0;
        repeat (2) cyc();

        // reset state
        expect_val("rst_frame", 64'h0);
        expect_val("rst_score", 64'd0);
        expect_val("rst_eog", 64'd0);
        expect_val("rst_win", 64'd0);
        expect_val("rst_currow", 64'd0);
        observe(lineDisplay); observe(score); observe(EOG); observe(win); observe(curRow);

        // start then two idle cycles
        rstBtn = 1'b0;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        repeat (2) cyc();
        expect_val("spawn_row0", bm(0, 3));
        expect_val("spawn_currow", 64'd0);
        expect_val("spawn_eog", 64'd0);
        expect_val("spawn_score", 64'd0);
        expect_val("spawn_width", 64'd3);
        observe(rowv(0)); observe(curRow); observe(EOG); observe(score); observe(blkWidth);

        // sweep to the right edge, bounce, then tick+drop together
        repeat (5) move(0);
        expect_val("sweep_pos5", bm(5, 3));
        observe(rowv(0));
        move(0);
        expect_val("bounce_right_pos4", bm(4, 3));
        observe(rowv(0));
        tick = 1'b1; dropBtn = 1'b1;
        cyc();
        tick = 1'b0; dropBtn = 1'b0;
        expect_val("tick_drop_hold", bm(4, 3));
        observe(rowv(0));

        // left edge bounce
        new_game();
        repeat (10) move(0);
        expect_val("left_pos0", bm(0, 3));
        observe(rowv(0));
        move(0);
        expect_val("bounce_left_frame", 64'(bm(1, 3)));
        observe(lineDisplay);

`ifdef STACKER_SPEEDUP_EN
        // divider: row 0 moves on every 4th tick
        new_game();
        repeat (3) begin tick = 1'b1; cyc(); tick = 1'b0; end
        expect_val("div_hold", bm(0, 3));
        observe(rowv(0));
        tick = 1'b1; cyc(); tick = 1'b0;
        expect_val("div_move", bm(1, 3));
        observe(rowv(0));
`endif

        // full stack to a win
        new_game();
        for (int r = 0; r < ROWS; r++) drop();
        expect_val("win_score", 64'd8);
        expect_val("win_eog", 64'd1);
        expect_val("win_win", 64'd1);
        expect_val("win_currow", 64'd7);
        expect_val("win_frame", 64'h0707070707070707);
        observe(score); observe(EOG); observe(win); observe(curRow); observe(lineDisplay);
        tick = 1'b1; dropBtn = 1'b1;
        repeat (2) cyc();
        tick = 1'b0; dropBtn = 1'b0;
        expect_val("win_frozen", 64'h0707070707070707);
        observe(lineDisplay);

        // trim
        new_game();
        drop();
        move(1);
        move(1);
        drop();
        expect_val("trim_row1", 64'(8'b0000_0100));
        expect_val("trim_width", 64'd1);
        expect_val("trim_row2", 64'(8'b0000_0001));
        expect_val("trim_row0", bm(0, 3));
        expect_val("trim_currow", 64'd2);
        expect_val("trim_score", 64'd2);
        observe(rowv(1)); observe(blkWidth); observe(rowv(2)); observe(rowv(0)); observe(curRow); observe(score);

        // miss
        new_game();
        drop();
        repeat (3) move(1);
        drop();
        expect_val("miss_eog", 64'd1);
        expect_val("miss_win", 64'd0);
        expect_val("miss_row1", bm(3, 3));
        expect_val("miss_score", 64'd1);
        observe(EOG); observe(win); observe(rowv(1)); observe(score);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        expect_val("restart_frame", 64'h07);
        expect_val("restart_score", 64'd0);
        expect_val("restart_eog", 64'd0);
        expect_val("restart_width", 64'd3);
        observe(lineDisplay); observe(score); observe(EOG); observe(blkWidth);

        // reset while playing row 4
        new_game();
        repeat (4) drop();
        move(4);
        expect_val("mid_currow", 64'd4);
        observe(curRow);
        rstBtn = 1'b1;
        cyc();
        rstBtn = 1'b0;
        expect_val("midrst_frame", 64'h0);
        expect_val("midrst_score", 64'd0);
        expect_val("midrst_currow", 64'd0);
        observe(lineDisplay); observe(score); observe(curRow);
        tick = 1'b1; dropBtn = 1'b1;
        repeat (3) cyc();
        tick = 1'b0; dropBtn = 1'b0;
        expect_val("idle_ignore", 64'h0);
        observe(lineDisplay);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        expect_val("idle_start_frame", 64'h07);
        observe(lineDisplay);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
